// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 device-to-host frame receiver.
//
// Receives 11-bit PS/2 frames: a start bit, 8 data bits (LSB first), a parity
// bit and a stop bit. Both lines are synchronised, and ps2c is glitch
// filtered. Data is sampled on each filtered ps2c falling edge. A watchdog
// aborts a frame that stalls.
//
// Parameters
//   FILTER_LEN  - consecutive identical ps2c samples needed to accept a change
//   TIMEOUT_CYC - clk cycles without a ps2c falling edge before a frame aborts
//
// Ports
//   clk   - system clock; all state changes on the rising edge
//   rst   - asynchronous, active-low reset
//   ps2c  - PS/2 clock line (asynchronous)
//   ps2d  - PS/2 data line (asynchronous)
//   rx_en - while high, a new frame may start
//   dato  - last valid scan code; held stable between tick pulses
//   tick  - one-cycle pulse when dato has just been updated
//   err   - one-cycle pulse on a stop, parity or timeout error
//
// Build option
//   PS2_PARITY_CHECK_EN - when defined, odd parity is checked and a parity
//                         failure gives err. When undefined, the parity bit
//                         is received and then ignored.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dato,
    output logic       tick,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, STOP} state_t;

    // Synchroniser and glitch filter. These reset to the idle line level (1),
    // so that no falling edge appears when reset is released.
    logic          ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
    logic          ps2c_f, ps2c_prev;
    logic [FW-1:0] fcnt;
    logic          fall_edge;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so that every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2c_s1   <= 1'b1;
            ps2c_s2   <= 1'b1;
            ps2d_s1   <= 1'b1;
            ps2d_s2   <= 1'b1;
            ps2c_f    <= 1'b1;
            ps2c_prev <= 1'b1;
            fcnt      <= '0;
        end else begin
            ps2c_s1   <= ps2c;
            ps2c_s2   <= ps2c_s1;
            ps2d_s1   <= ps2d;
            ps2d_s2   <= ps2d_s1;
            ps2c_prev <= ps2c_f;
            // A run of differing samples must be unbroken. The filtered level
            // flips on the FILTER_LEN-th sample of the run.
            if (ps2c_s2 != ps2c_f) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    ps2c_f <= ps2c_s2;
                    fcnt   <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall_edge = ps2c_prev & ~ps2c_f;

    // Frame FSM
    state_t        state, state_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [8:0]    shreg, shreg_nx;     // {parity, data[7:0]} once complete
    logic [WW-1:0] wdog, wdog_nx;
    logic [7:0]    dato_nx;
    logic          tick_nx, err_nx;
    logic          timeout, parity_ok, frame_ok;

    assign timeout = (state != IDLE) && (wdog == WW'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^shreg;          // odd number of ones across data+parity
`else
    assign parity_ok = 1'b1;
`endif

    // ps2d_s2 holds the stop bit in the STOP-state falling-edge cycle.
    assign frame_ok = ps2d_s2 & parity_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            wdog    <= '0;
            dato    <= 8'h00;
            tick    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
            wdog    <= wdog_nx;
            dato    <= dato_nx;
            tick    <= tick_nx;
            err     <= err_nx;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        dato_nx    = dato;
        tick_nx    = 1'b0;
        err_nx     = 1'b0;
        wdog_nx    = (state == IDLE || fall_edge) ? '0 : wdog + 1'b1;

        // Timeout takes priority over a coincident edge. Because of this,
        // tick and err can never come from the same cycle.
        if (timeout) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            err_nx     = 1'b1;
        end else if (fall_edge) begin
            unique case (state)
                IDLE: begin
                    if (rx_en && !ps2d_s2) begin
                        state_nx   = RECV;
                        bit_cnt_nx = '0;
                    end
                end
                RECV: begin
                    shreg_nx = {ps2d_s2, shreg[8:1]};
                    if (bit_cnt == 4'd8) begin
                        state_nx = STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end
                end
                STOP: begin
                    state_nx   = IDLE;
                    bit_cnt_nx = '0;
                    if (frame_ok) begin
                        dato_nx = shreg[7:0];
                        tick_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
